// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg -- shared definitions for the multiply/divide scheduler.
//   * MD_OP_* : issue_op encodings presented by decode
//   * md_state_t : scheduler FSM states
//   * MD_WDOG_CYCLES_DEFAULT : default unit-completion watchdog limit
//   * md_op_is_signed() : signedness of an MD arithmetic op
// ---------------------------------------------------------------------------
package md_pkg;

  localparam logic [2:0] MD_OP_MULT  = 3'b000;
  localparam logic [2:0] MD_OP_MULTU = 3'b001;
  localparam logic [2:0] MD_OP_DIV   = 3'b010;
  localparam logic [2:0] MD_OP_DIVU  = 3'b011;
  localparam logic [2:0] MD_OP_MTHI  = 3'b100;
  localparam logic [2:0] MD_OP_MTLO  = 3'b101;

  localparam int MD_WDOG_CYCLES_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DRAIN    = 2'd3
  } md_state_t;

  function automatic logic md_op_is_signed(input logic [2:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// ---------------------------------------------------------------------------
// md_sched_if -- bundle of all scheduler-facing signals.
//   issue bus  : issue_valid/op/src1/src2 -> issue_ready, plus flush
//   unit bus   : mul_en/div_en/md_signed/md_src1/md_src2 out,
//                mul_complete/mul_result, div_complete/quotient/remainder in
//   mf bus     : mf_req/mf_sel -> mf_data/mf_stall
//   status     : md_busy, md_timeout, hi, lo
// Modports: slave = the scheduler, master = its environment (decode/units).
// ---------------------------------------------------------------------------
interface md_sched_if #(
  parameter int WIDTH = 32
) ();

  logic               issue_valid;
  logic [2:0]         issue_op;
  logic [WIDTH-1:0]   issue_src1;
  logic [WIDTH-1:0]   issue_src2;
  logic               issue_ready;
  logic               flush;

  logic               mul_en;
  logic               div_en;
  logic               md_signed;
  logic [WIDTH-1:0]   md_src1;
  logic [WIDTH-1:0]   md_src2;
  logic               mul_complete;
  logic [2*WIDTH-1:0] mul_result;
  logic               div_complete;
  logic [WIDTH-1:0]   div_quotient;
  logic [WIDTH-1:0]   div_remainder;

  logic               mf_req;
  logic               mf_sel;
  logic [WIDTH-1:0]   mf_data;
  logic               mf_stall;

  logic               md_busy;
  logic               md_timeout;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport slave (
    input  issue_valid, issue_op, issue_src1, issue_src2, flush,
    input  mul_complete, mul_result, div_complete, div_quotient, div_remainder,
    input  mf_req, mf_sel,
    output issue_ready, mul_en, div_en, md_signed, md_src1, md_src2,
    output mf_data, mf_stall, md_busy, md_timeout, hi, lo
  );

  modport master (
    output issue_valid, issue_op, issue_src1, issue_src2, flush,
    output mul_complete, mul_result, div_complete, div_quotient, div_remainder,
    output mf_req, mf_sel,
    input  issue_ready, mul_en, div_en, md_signed, md_src1, md_src2,
    input  mf_data, mf_stall, md_busy, md_timeout, hi, lo
  );

endinterface

// File: rtl/md_wdog.sv
// ---------------------------------------------------------------------------
// md_wdog -- completion watchdog counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the count (takes priority over enable)
//   enable     : count one cycle of waiting
//   expire     : combinational, high while enabled at count WDOG_CYCLES-1
// expire does not depend on clear, so the owner may derive clear from a
// next-state that itself depends on expire without forming a loop.
// ---------------------------------------------------------------------------
module md_wdog #(
  parameter int WDOG_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expire = enable && (count_reg == CW'(WDOG_CYCLES - 1));

endmodule

// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched -- scheduler for the shared multiply/divide resource.
//   clk, reset : clock, synchronous active-high reset
//   bus        : md_sched_if.slave (issue, unit launch/completion, MF read,
//                status and architectural HI/LO)
// Accepted MULT*/DIV* ops latch operands and pulse mul_en/div_en for one
// cycle, then wait for the unit's completion which is written to HI/LO.
// A flush while waiting moves to DRAIN, which swallows the next completion.
// A watchdog returns to IDLE if a unit never completes.
// Build option: MD_SCHED_BYPASS_EN forwards an accepted completion straight
// to mf_data in its own cycle instead of stalling until the register update.
// ---------------------------------------------------------------------------
module md_sched
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int WDOG_CYCLES = MD_WDOG_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  md_sched_if.slave   bus
);

  md_state_t        state_reg, state_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] src1_reg, src1_next;
  logic [WIDTH-1:0] src2_reg, src2_next;
  logic             signed_reg, signed_next;
  logic             mul_en_reg, mul_en_next;
  logic             div_en_reg, div_en_next;
  logic             timeout_reg, timeout_next;

  logic             issue_ready;
  logic             accept;
  logic             wdog_expire;
  logic             cap_valid;
  logic [WIDTH-1:0] cap_hi;
  logic [WIDTH-1:0] cap_lo;

  assign issue_ready = (state_reg == ST_IDLE) && !bus.flush;
  assign accept      = bus.issue_valid && issue_ready;

  // Watchdog restarts whenever the state changes and runs while waiting.
  md_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_next != state_reg),
    .enable (state_reg != ST_IDLE),
    .expire (wdog_expire)
  );

  // Completion that will be committed this cycle (waited unit, not flushed).
  always_comb begin
    cap_valid = 1'b0;
    cap_hi    = bus.mul_result[2*WIDTH-1:WIDTH];
    cap_lo    = bus.mul_result[WIDTH-1:0];
    if (state_reg == ST_MUL_WAIT && bus.mul_complete && !bus.flush) begin
      cap_valid = 1'b1;
    end else if (state_reg == ST_DIV_WAIT && bus.div_complete && !bus.flush) begin
      cap_valid = 1'b1;
      cap_hi    = bus.div_remainder;
      cap_lo    = bus.div_quotient;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    src1_next    = src1_reg;
    src2_next    = src2_reg;
    signed_next  = signed_reg;
    mul_en_next  = 1'b0;
    div_en_next  = 1'b0;
    timeout_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (bus.issue_op)
            MD_OP_MULT, MD_OP_MULTU: begin
              src1_next   = bus.issue_src1;
              src2_next   = bus.issue_src2;
              signed_next = md_op_is_signed(bus.issue_op);
              mul_en_next = 1'b1;
              state_next  = ST_MUL_WAIT;
            end
            MD_OP_DIV, MD_OP_DIVU: begin
              // Divide by zero is architecturally undefined: leave HI/LO alone.
              if (bus.issue_src2 != '0) begin
                src1_next   = bus.issue_src1;
                src2_next   = bus.issue_src2;
                signed_next = md_op_is_signed(bus.issue_op);
                div_en_next = 1'b1;
                state_next  = ST_DIV_WAIT;
              end
            end
            MD_OP_MTHI: hi_next = bus.issue_src1;
            MD_OP_MTLO: lo_next = bus.issue_src1;
            default: ;
          endcase
        end
      end

      ST_MUL_WAIT, ST_DIV_WAIT: begin
        if ((state_reg == ST_MUL_WAIT && bus.mul_complete) ||
            (state_reg == ST_DIV_WAIT && bus.div_complete)) begin
          // A completion coinciding with flush is dropped but still ends the wait.
          if (cap_valid) begin
            hi_next = cap_hi;
            lo_next = cap_lo;
          end
          state_next = ST_IDLE;
        end else if (wdog_expire) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end else if (bus.flush) begin
          state_next = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (bus.mul_complete || bus.div_complete) begin
          state_next = ST_IDLE;
        end else if (wdog_expire) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      hi_reg      <= '0;
      lo_reg      <= '0;
      src1_reg    <= '0;
      src2_reg    <= '0;
      signed_reg  <= 1'b0;
      mul_en_reg  <= 1'b0;
      div_en_reg  <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      src1_reg    <= src1_next;
      src2_reg    <= src2_next;
      signed_reg  <= signed_next;
      mul_en_reg  <= mul_en_next;
      div_en_reg  <= div_en_next;
      timeout_reg <= timeout_next;
    end
  end

  // MF read path.
  always_comb begin
    bus.mf_data  = bus.mf_sel ? hi_reg : lo_reg;
    bus.mf_stall = bus.mf_req && (state_reg != ST_IDLE);
`ifdef MD_SCHED_BYPASS_EN
    if (cap_valid) begin
      bus.mf_data  = bus.mf_sel ? cap_hi : cap_lo;
      bus.mf_stall = 1'b0;
    end
`endif
  end

  assign bus.issue_ready = issue_ready;
  assign bus.mul_en      = mul_en_reg;
  assign bus.div_en      = div_en_reg;
  assign bus.md_signed   = signed_reg;
  assign bus.md_src1     = src1_reg;
  assign bus.md_src2     = src2_reg;
  assign bus.md_busy     = (state_reg != ST_IDLE);
  assign bus.md_timeout  = timeout_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Scheduler for the shared multiply/divide resource in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues from decode and launches the external mul and div units with one-cycle enable pulses.
- Captures completions into the architectural HI/LO registers.
- Stalls MFHI/MFLO reads while a result is outstanding, and discards results of instructions flushed by an exception.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- WDOG_CYCLES, 64, maximum wait for a unit completion before forced recovery.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an MD op.
- issue_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are no-op.
- issue_src1  in  WIDTH  rs value.
- issue_src2  in  WIDTH  rt value.
- issue_ready  out  1  scheduler can accept an issue this cycle.
- flush  in  1  exception cancels any in-flight or presented MD op.
- mul_en  out  1  one-cycle start pulse to the multiplier.
- div_en  out  1  one-cycle start pulse to the divider.
- md_signed  out  1  signed operation.
- md_src1  out  WIDTH  latched operand x / dividend.
- md_src2  out  WIDTH  latched operand y / divisor.
- mul_complete  in  1  multiplier result valid (one cycle).
- mul_result  in  2*WIDTH  {hi,lo} product.
- div_complete  in  1  divider result valid (one cycle).
- div_quotient  in  WIDTH  quotient.
- div_remainder  in  WIDTH  remainder.
- mf_req  in  1  MFHI/MFLO in execute.
- mf_sel  in  1  1 = HI, 0 = LO.
- mf_data  out  WIDTH  selected HI/LO value.
- mf_stall  out  1  hold the pipeline; mf_data not valid.
- md_busy  out  1  state != IDLE.
- md_timeout  out  1  one-cycle pulse on watchdog expiry.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state IDLE. hi, lo, md_src1, md_src2 = 0. mul_en, div_en, md_signed, md_timeout = 0. Watchdog count = 0. issue_ready = 1 from the first cycle after reset deasserts.
- States: IDLE, MUL_WAIT, DIV_WAIT, DRAIN. issue_ready = (state == IDLE) & ~flush.
- Acceptance at cycle T requires issue_valid & issue_ready.
- MULT/MULTU at T:
  - md_src1/md_src2/md_signed latched at T.
  - mul_en = 1 at T+1 only; state = MUL_WAIT from T+1.
- DIV/DIVU at T:
  - Same timing, using div_en and DIV_WAIT.
  - If issue_src2 == 0: no launch, state stays IDLE, HI/LO unchanged.
- MTHI/MTLO at T: hi or lo = issue_src1 at T+1; state stays IDLE; back-to-back issues allowed.
- Completion:
  - mul_complete at cycle C in MUL_WAIT: hi = mul_result[2W-1:W], lo = mul_result[W-1:0] at C+1; state IDLE at C+1.
  - div_complete in DIV_WAIT: hi = remainder, lo = quotient.
  - A completion from the non-waited unit is ignored.
- Flush:
  - flush in MUL_WAIT/DIV_WAIT → DRAIN. In DRAIN the next complete is discarded, then IDLE.
  - flush in the same cycle as complete: result discarded, → IDLE.
  - flush with issue_valid in IDLE: not accepted, no launch.
  - flush during the T+1 launch cycle: mul_en/div_en still pulse; state enters DRAIN.
- Watchdog:
  - Counter clears on entry to any wait state and increments each cycle in MUL_WAIT/DIV_WAIT/DRAIN.
  - At WDOG_CYCLES-1 without completion: md_timeout pulses, state → IDLE, HI/LO unchanged.
- MF read:
  - mf_stall = mf_req & (state != IDLE).
  - Otherwise mf_data = mf_sel ? hi : lo, combinational from registers.
  - An MTHI/MTLO accepted at T is visible to mf_data from T+1.
- Simultaneous issue and mf_req in IDLE: mf_data returns the pre-issue HI/LO.
- Reset mid-operation: immediate return to reset values; any later unit completion is ignored because state is IDLE.

Optional Feature:
- Macro MD_SCHED_BYPASS_EN.
- Defined: during a wait state, on the cycle of an accepted (non-discarded) completion, mf_stall = 0 and mf_data = the incoming HI/LO value. The MF read finishes one cycle earlier.
- Undefined: mf_stall stays high through the completion cycle; data is read from the registers at C+1.

Decomposition:
- Shared package md_pkg:
  - issue_op codes (MD_OP_MULT … MD_OP_MTLO).
  - State enum md_state_t.
  - Default WDOG_CYCLES constant.
- One sub-module md_wdog: clear/enable counter with expiry pulse, parameterised by WDOG_CYCLES.

Test Plan:
- MULT src1=0xFFFFFFFE (-2), src2=3 → mul_en at T+1 with md_signed=1; complete result 0xFFFFFFFF_FFFFFFFA → hi=0xFFFFFFFF, lo=0xFFFFFFFA at C+1; issue_ready returns to 1.
- DIVU 100/7 with complete 4 cycles after launch → lo=14, hi=2; an mf_req with mf_sel=0 during the wait sees mf_stall=1, then mf_data=14 (bypass off: at C+1).
- DIV src2=0 → no div_en, HI/LO unchanged, md_busy stays 0.
- MULT launched, flush 2 cycles later, complete 3 cycles later → DRAIN, hi/lo unchanged, IDLE after the complete.
- MTHI 0x1234 then MTLO 0x5678 on back-to-back cycles → hi=0x1234, lo=0x5678; an MFHI in the cycle after returns 0x1234 with no stall.
- DIV launched with no complete ever → md_timeout pulse WDOG_CYCLES cycles after entry to DIV_WAIT; state IDLE; reset asserted mid-wait on a second run clears hi/lo to 0.
